interval_timer: RTL

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer_pkg.sv | 27 ++
 rtl/interval_timer.sv | 84 ++++++++
 2 files changed

// File: rtl/interval_timer_pkg.sv
// Shared traffic-system definitions: interval select codes, timer FSM states
// and the interval-code validity helper used by the timer and the parameter store.
package interval_timer_pkg;

    localparam int unsigned INTERVAL_W = 2;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [INTERVAL_W-1:0] {
        INT_BASE    = 2'b00,
        INT_EXT     = 2'b01,
        INT_YELLOW  = 2'b10,
        INT_INVALID = 2'b11
    } interval_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_LOAD   = 3'd2,
        ST_COUNT  = 3'd3,
        ST_DONE   = 3'd4
    } timer_state_e;

    function automatic logic interval_valid(input logic [INTERVAL_W-1:0] code);
        return code != INT_INVALID;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Interval timer: selects an interval in the parameter store, loads its value
// after the store's read latency, then counts it down on tick_En.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_Timer,
    input  logic [INTERVAL_W-1:0] req_Interval,
    input  logic                  tick_En,
    input  logic [CNT_W-1:0]      value_In,
    output logic [INTERVAL_W-1:0] interval,
    output logic                  expired,
    output logic                  busy,
    output logic [CNT_W-1:0]      remaining
);

    timer_state_e          state;
    timer_state_e          state_nxt;
    logic [INTERVAL_W-1:0] interval_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  start_ok;

    assign start_ok = start_Timer && interval_valid(req_Interval);

    // State, select, counter and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            interval  <= INT_BASE;
            remaining <= '0;
            expired   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            interval  <= interval_nxt;
            remaining <= count_nxt;
            expired   <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    // A valid start is accepted from any state; outside IDLE/DONE it aborts
    always_comb begin
        state_nxt    = state;
        interval_nxt = interval;
        count_nxt    = remaining;
        if (start_ok) begin
            state_nxt    = ST_SELECT;
            interval_nxt = req_Interval;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_SELECT: begin
                    state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    count_nxt = value_In;
                    state_nxt = (value_In == '0) ? ST_DONE : ST_COUNT;
                end
                ST_COUNT: begin
                    // Saturating guard keeps the counter from wrapping below zero
                    if (tick_En && (remaining != '0)) begin
                        count_nxt = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule
